// File: rtl/megaram_mapper_gen.sv
// MegaRAM/ROM mapper for the MSX cartridge slot: four bank registers, four mapper modes,
// strobe qualification with single commit per bus cycle, I/O mode/readback ports.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for a synchronised rd/wr strobe
// S_COMMIT | one clock: performs the decoded register/mode action
// S_HOLD   | action done; waits for rd_n and wr_n both high
module megaram_mapper_gen #(
   parameter int                PAGE_W    = 8,
   parameter logic [PAGE_W-1:0] PAGE_MASK = 8'hFF,
   parameter logic [22:0]       MEM_BASE  = 23'h420000,
   parameter logic [7:0]        MODE_PORT = 8'h8E
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic [1:0]  i_mapper_type,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_cdin,
   input  logic        i_sltsl_n,
   input  logic        i_merq_n,
   input  logic        i_iorq_n,
   input  logic        i_m1_n,
   input  logic        i_rd_n,
   input  logic        i_wr_n,
   output logic [7:0]  o_cdout,
   output logic        o_cdout_oe,
   output logic        o_ram_ena,
   output logic        o_cart_ena,
   output logic [22:0] o_mem_addr
);

   localparam int         OFF_W   = PAGE_W + 13;
   localparam logic [7:0] RB_PORT = MODE_PORT + 8'd1;

   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_HOLD} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_commit;
   logic [5:0]        r_sync1;
   logic [5:0]        r_sync2;
   logic [1:0]        r_warm;
   logic              r_armed;
   logic [PAGE_W-1:0] r_bank [4];
   logic              r_ram_ena;
   logic [1:0]        r_rb_idx;
   logic [7:0]        r_cdout;
   logic              r_cdout_oe;
   logic [1:0]        r_type_q;

   logic w_sltsl_s, w_merq_s, w_iorq_s, w_m1_s, w_rd_s, w_wr_s;
   logic w_bus_idle, w_win, w_io, w_io_mode, w_io_rb, w_mem_wr, w_bank_we, w_type_chg;
   logic [1:0]        w_bank_sel;
   logic [1:0]        w_page_idx;
   logic [PAGE_W-1:0] w_page;
   logic [OFF_W-1:0]  w_off;

   assign {w_sltsl_s, w_merq_s, w_iorq_s, w_m1_s, w_rd_s, w_wr_s} = r_sync2;
   assign w_bus_idle = w_wr_s & w_rd_s;
   assign w_win      = (i_addr[15:14] == 2'b01) | (i_addr[15:14] == 2'b10);
   assign o_cart_ena = w_win & ~i_sltsl_n & ~i_merq_n & i_iorq_n;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_warm  <= '0;
      end else begin
         r_sync1 <= {i_sltsl_n, i_merq_n, i_iorq_n, i_m1_n, i_rd_n, i_wr_n};
         r_sync2 <= r_sync1;
         r_warm  <= {r_warm[0], 1'b1};
      end
   end

   // Only arm once the synchronisers carry real samples and the bus was seen idle,
   // so a strobe still low across reset release (or re-enable) never commits.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_armed <= i_en & (r_armed | (r_warm[1] & w_bus_idle));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      if (!i_en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (r_armed & ~w_bus_idle) w_state_nxt = S_COMMIT;
            S_COMMIT: begin
               w_commit    = 1'b1;
               w_state_nxt = S_HOLD;
            end
            S_HOLD:   if (w_bus_idle) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_io      = ~w_iorq_s & w_m1_s;
   assign w_io_mode = w_io & (i_addr[7:0] == MODE_PORT);
   assign w_io_rb   = w_io & (i_addr[7:0] == RB_PORT);
   assign w_mem_wr  = w_win & ~w_sltsl_s & ~w_merq_s & w_iorq_s & ~w_wr_s & ~r_ram_ena;

   always_comb begin
      w_bank_we  = 1'b0;
      w_bank_sel = {i_addr[15], i_addr[13]};
      case (i_mapper_type)
         2'b00: w_bank_we = 1'b1;
         2'b01: w_bank_we = (i_addr[12:11] == 2'b10);
         2'b11: begin
            w_bank_we  = (i_addr[15:13] == 3'b011);
            w_bank_sel = i_addr[12:11];
         end
         default: begin
            w_bank_we  = (i_addr[15:11] == 5'b01100) | (i_addr[15:11] == 5'b01110);
            w_bank_sel = {1'b0, i_addr[12]};
         end
      endcase
   end

   assign w_type_chg = i_en & (i_mapper_type != r_type_q);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < 4; i++) r_bank[i] <= PAGE_W'(i);
         r_ram_ena  <= 1'b0;
         r_rb_idx   <= 2'd0;
         r_cdout    <= 8'h00;
         r_cdout_oe <= 1'b0;
         r_type_q   <= 2'b00;
      end else begin
         if (i_en) r_type_q <= i_mapper_type;
         if (w_type_chg) begin
            for (int i = 0; i < 4; i++) r_bank[i] <= PAGE_W'(i);
         end else if (w_commit & w_mem_wr & w_bank_we) begin
            r_bank[w_bank_sel] <= PAGE_W'(i_cdin);
         end
         if (w_commit & w_io_mode) r_ram_ena <= w_wr_s;
         if (w_commit & w_io_rb & ~w_wr_s) r_rb_idx <= i_cdin[1:0];
         if (w_commit & w_io_rb & w_wr_s) begin
            r_cdout    <= 8'(r_bank[r_rb_idx]);
            r_cdout_oe <= 1'b1;
         end else if (w_state_nxt == S_IDLE) begin
            r_cdout_oe <= 1'b0;
         end
      end
   end

   // ASCII16 pages are 16K, so one fewer page bit feeds the offset
   assign w_page_idx = (i_mapper_type == 2'b10) ? {1'b0, i_addr[15]} : {i_addr[15], i_addr[13]};
   assign w_page     = r_bank[w_page_idx] & PAGE_MASK;
   assign w_off      = (i_mapper_type == 2'b10) ? {w_page[PAGE_W-2:0], i_addr[13:0]}
                                                : {w_page, i_addr[12:0]};
   assign o_mem_addr = MEM_BASE + 23'(w_off);

   assign o_cdout    = r_cdout;
   assign o_cdout_oe = r_cdout_oe;
   assign o_ram_ena  = r_ram_ena;

endmodule
